// File: rtl/crypt_sched.sv
// Round-robin scheduler sharing one 64-bit crypto core between the decrypt and encrypt paths.
// Each job pops one source block, runs the core (with a timeout), and pushes the result to the matching sink.
module crypt_sched #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [63:0]      key,
  input  logic             err_clr,
  input  logic             dec_src_empty,
  input  logic             enc_src_empty,
  output logic             dec_src_ren,
  output logic             enc_src_ren,
  input  logic [63:0]      dec_src_rdata,
  input  logic [63:0]      enc_src_rdata,
  input  logic             dec_snk_full,
  input  logic             enc_snk_full,
  output logic             dec_snk_wen,
  output logic             enc_snk_wen,
  output logic [63:0]      snk_wdata,
  output logic             core_start,
  output logic             core_mode,
  output logic [63:0]      core_din,
  output logic [63:0]      core_key,
  input  logic             core_done,
  input  logic [63:0]      core_dout,
  output logic             core_abort,
  output logic             busy,
  output logic             err_timeout,
  output logic [CNT_W-1:0] dec_cnt,
  output logic [CNT_W-1:0] enc_cnt
);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_POP, S_LOAD, S_START, S_WAIT, S_PUSH} state_t;

  state_t           state_q, state_d;
  logic             sel_q, sel_d;    // 1 = decrypt path granted
  logic             rr_q, rr_d;      // 1 = encrypt path preferred on a tie
  logic [63:0]      din_q, din_d;
  logic [63:0]      key_q, key_d;
  logic [63:0]      dout_q, dout_d;
  logic [TW-1:0]    wcnt_q, wcnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d;
  logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;

  logic dec_elig, enc_elig, timeout_hit;

  assign dec_elig    = !dec_src_empty && !dec_snk_full;
  assign enc_elig    = !enc_src_empty && !enc_snk_full;
  assign timeout_hit = (wcnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rr_d      = rr_q;
    din_d     = din_q;
    key_d     = key_q;
    dout_d    = dout_q;
    wcnt_d    = wcnt_q;
    err_d     = err_q;
    dec_cnt_d = dec_cnt_q;
    enc_cnt_d = enc_cnt_q;
    if (err_clr) err_d = 1'b0;
    case (state_q)
      S_IDLE: if (enable && (dec_elig || enc_elig)) begin
        sel_d   = dec_elig && (!enc_elig || !rr_q);
        key_d   = key;
        state_d = S_POP;
      end
      S_POP:   state_d = S_LOAD;
      S_LOAD: begin
        din_d   = sel_q ? dec_src_rdata : enc_src_rdata;
        state_d = S_START;
      end
      S_START: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion in the last wait cycle beats the timeout.
        if (core_done) begin
          dout_d  = core_dout;
          state_d = S_PUSH;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          rr_d    = sel_q;
          state_d = S_IDLE;
        end else begin
          wcnt_d  = wcnt_q + TW'(1);
        end
      end
      S_PUSH: begin
        if (sel_q) dec_cnt_d = dec_cnt_q + CNT_W'(1);
        else       enc_cnt_d = enc_cnt_q + CNT_W'(1);
        // Point the tie-breaker at the path that did not just run.
        rr_d    = sel_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sel_q     <= 1'b0;
      rr_q      <= 1'b0;
      din_q     <= '0;
      key_q     <= '0;
      dout_q    <= '0;
      wcnt_q    <= '0;
      err_q     <= 1'b0;
      dec_cnt_q <= '0;
      enc_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rr_q      <= rr_d;
      din_q     <= din_d;
      key_q     <= key_d;
      dout_q    <= dout_d;
      wcnt_q    <= wcnt_d;
      err_q     <= err_d;
      dec_cnt_q <= dec_cnt_d;
      enc_cnt_q <= enc_cnt_d;
    end
  end

  assign dec_src_ren = (state_q == S_POP)  &&  sel_q;
  assign enc_src_ren = (state_q == S_POP)  && !sel_q;
  assign dec_snk_wen = (state_q == S_PUSH) &&  sel_q;
  assign enc_snk_wen = (state_q == S_PUSH) && !sel_q;
  assign snk_wdata   = dout_q;
  assign core_start  = (state_q == S_START);
  assign core_mode   = sel_q;
  assign core_din    = din_q;
  assign core_key    = key_q;
  assign core_abort  = (state_q == S_WAIT) && timeout_hit && !core_done;
  assign busy        = (state_q != S_IDLE);
  assign err_timeout = err_q;
  assign dec_cnt     = dec_cnt_q;
  assign enc_cnt     = enc_cnt_q;
endmodule

// File: tb/tb_crypt_sched.sv
// Scoreboard bench for crypt_sched: FIFO and core models feed the DUT, a monitor checks every sink push.
module tb_crypt_sched;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 16;

  logic clk = 0, rst = 1, enable = 0, err_clr = 0;
  logic [63:0] key = '0;
  logic dec_src_empty = 1, enc_src_empty = 1;
  logic [63:0] dec_src_rdata = '0, enc_src_rdata = '0;
  logic dec_snk_full = 0, enc_snk_full = 0;
  logic core_done = 0;
  logic [63:0] core_dout = '0;
  logic dec_src_ren, enc_src_ren, dec_snk_wen, enc_snk_wen;
  logic [63:0] snk_wdata, core_din, core_key;
  logic core_start, core_mode, core_abort, busy, err_timeout;
  logic [CNT_W-1:0] dec_cnt, enc_cnt;

  crypt_sched #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .key(key), .err_clr(err_clr),
    .dec_src_empty(dec_src_empty), .enc_src_empty(enc_src_empty),
    .dec_src_ren(dec_src_ren), .enc_src_ren(enc_src_ren),
    .dec_src_rdata(dec_src_rdata), .enc_src_rdata(enc_src_rdata),
    .dec_snk_full(dec_snk_full), .enc_snk_full(enc_snk_full),
    .dec_snk_wen(dec_snk_wen), .enc_snk_wen(enc_snk_wen), .snk_wdata(snk_wdata),
    .core_start(core_start), .core_mode(core_mode), .core_din(core_din), .core_key(core_key),
    .core_done(core_done), .core_dout(core_dout), .core_abort(core_abort),
    .busy(busy), .err_timeout(err_timeout), .dec_cnt(dec_cnt), .enc_cnt(enc_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Source FIFOs: data stays at the head through the cycle after ren, then is popped.
  logic [63:0] dec_q[$], enc_q[$];
  logic [1:0] dec_pp = 0, enc_pp = 0;
  always begin
    @(negedge clk);
    if (dec_pp[1]) void'(dec_q.pop_front());
    if (enc_pp[1]) void'(enc_q.pop_front());
    dec_pp = {dec_pp[0], dec_src_ren};
    enc_pp = {enc_pp[0], enc_src_ren};
    #1;
    dec_src_empty = (dec_q.size() == 0);
    enc_src_empty = (enc_q.size() == 0);
    dec_src_rdata = dec_src_empty ? 64'h0 : dec_q[0];
    enc_src_rdata = enc_src_empty ? 64'h0 : enc_q[0];
  end

  // Core model: per job, a latency (WAIT cycle of done, <=0 means never) and a response word.
  int lat_q[$];
  logic [63:0] resp_q[$], din_log[$];
  always begin : core_model
    int lat;
    @(negedge clk);
    if (core_start) begin
      din_log.push_back(core_din);
      lat = (lat_q.size() != 0) ? lat_q.pop_front() : -1;
      if (lat > 0) begin
        repeat (lat) @(negedge clk);
        core_done = 1;
        core_dout = resp_q.pop_front();
        @(negedge clk);
        core_done = 0;
        core_dout = '0;
      end
    end
  end

  // Scoreboard monitor.
  typedef struct { logic dec; logic [63:0] data; int gap; } exp_t;
  exp_t exp_q[$];
  int ren_cyc = 0, bad_ren = 0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (dec_src_ren || enc_src_ren) ren_cyc = cyc;
    if (dec_src_ren && dec_snk_full) bad_ren++;
    if (enc_src_ren && enc_snk_full) bad_ren++;
    if (dec_snk_wen || enc_snk_wen) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_wen got dec=%0b enc=%0b data=%h exp none", dec_snk_wen, enc_snk_wen, snk_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wen_path", {63'h0, dec_snk_wen}, {63'h0, e.dec});
        chk("wen_excl", {63'h0, dec_snk_wen & enc_snk_wen}, 64'h0);
        chk("wen_data", snk_wdata, e.data);
        chk("wen_gap", 64'(cyc - ren_cyc), 64'(e.gap));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic job(input logic dec, input logic [63:0] src, input int lat, input logic [63:0] resp);
    if (dec) dec_q.push_back(src); else enc_q.push_back(src);
    lat_q.push_back(lat);
    if (lat > 0) begin
      resp_q.push_back(resp);
      exp_q.push_back('{dec, resp, 3 + lat});
    end
  endtask

  task automatic wait_for(input int which, input string nm, output int c);
    logic hit;
    hit = 0;
    for (int n = 0; n < 300 && !hit; n++) begin
      @(negedge clk);
      case (which)
        0: hit = core_start;
        1: hit = core_abort;
        default: hit = dec_src_ren || enc_src_ren;
      endcase
    end
    c = cyc;
    if (!hit) begin total++; bad++; $display("FAIL %s wait expired got none exp event", nm); end
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while ((exp_q.size() != 0 || busy) && n < budget);
    if (exp_q.size() != 0 || busy) begin
      total++; bad++;
      $display("FAIL %s drain expired got pending=%0d busy=%0b exp 0", nm, exp_q.size(), busy);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ren"},   {62'h0, dec_src_ren, enc_src_ren}, 64'h0);
    chk({nm, "_wen"},   {62'h0, dec_snk_wen, enc_snk_wen}, 64'h0);
    chk({nm, "_start"}, {63'h0, core_start}, 64'h0);
    chk({nm, "_abort"}, {63'h0, core_abort}, 64'h0);
    chk({nm, "_busy"},  {63'h0, busy}, 64'h0);
    chk({nm, "_err"},   {63'h0, err_timeout}, 64'h0);
    chk({nm, "_mode"},  {63'h0, core_mode}, 64'h0);
    chk({nm, "_cnt"},   {32'h0, dec_cnt, enc_cnt}, 64'h0);
    chk({nm, "_din"},   core_din, 64'h0);
    chk({nm, "_key"},   core_key, 64'h0);
    chk({nm, "_wdata"}, snk_wdata, 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, a;
    tick(3);
    chk_reset_outputs("reset");
    rst = 0;

    // Single decrypt job.
    key = 64'h0123456789ABCDEF;
    job(1, 64'hDEAD_BEEF_0000_0001, 1, 64'h1111);
    enable = 1;
    wait_for(0, "t1_start", s);
    chk("t1_mode", {63'h0, core_mode}, 64'h1);
    chk("t1_key", core_key, 64'h0123456789ABCDEF);
    chk("t1_din", core_din, 64'hDEAD_BEEF_0000_0001);
    wait_drain("t1", 50);
    chk("t1_cnt", {32'h0, dec_cnt, enc_cnt}, {32'h0, 16'd1, 16'd0});

    // Backpressure: dec sink full, only enc may run.
    enable = 0;
    dec_snk_full = 1;
    dec_q.push_back(64'hA0A0_0000_0000_0001);
    job(0, 64'hB0B0_0000_0000_0001, 2, 64'h2222);
    tick(1);
    enable = 1;
    wait_drain("t3", 50);
    tick(4);
    enable = 0;
    chk("t3_ren_while_full", 64'(bad_ren), 64'h0);
    chk("t3_cnt", {32'h0, dec_cnt, enc_cnt}, {32'h0, 16'd1, 16'd1});

    // Both paths eligible: strict alternation starting with dec.
    dec_snk_full = 0;
    din_log.delete();
    lat_q.push_back(1); resp_q.push_back(64'h3333_0001); exp_q.push_back('{1'b1, 64'h3333_0001, 4});
    job(0, 64'hB1, 1, 64'h3333_0002);
    job(1, 64'hA2, 1, 64'h3333_0003);
    job(0, 64'hB2, 1, 64'h3333_0004);
    tick(1);
    enable = 1;
    wait_drain("t2", 200);
    enable = 0;
    chk("t2_cnt", {32'h0, dec_cnt, enc_cnt}, {32'h0, 16'd3, 16'd3});
    chk("t2_njobs", 64'(din_log.size()), 64'd4);
    if (din_log.size() == 4) begin
      chk("t2_din0", din_log[0], 64'hA0A0_0000_0000_0001);
      chk("t2_din1", din_log[1], 64'hB1);
      chk("t2_din2", din_log[2], 64'hA2);
      chk("t2_din3", din_log[3], 64'hB2);
    end

    // Timeout: core never answers.
    job(0, 64'hC0DE, -1, 64'h0);
    enable = 1;
    wait_for(0, "t4_start", s);
    chk("t4_mode", {63'h0, core_mode}, 64'h0);
    wait_for(1, "t4_abort", a);
    enable = 0;
    chk("t4_abort_delay", 64'(a - s), 64'd64);
    tick(1);
    chk("t4_err", {63'h0, err_timeout}, 64'h1);
    chk("t4_busy", {63'h0, busy}, 64'h0);
    tick(2);
    chk("t4_err_sticky", {63'h0, err_timeout}, 64'h1);
    chk("t4_cnt", {32'h0, dec_cnt, enc_cnt}, {32'h0, 16'd3, 16'd3});
    err_clr = 1;
    tick(1);
    err_clr = 0;
    chk("t4_err_clr", {63'h0, err_timeout}, 64'h0);

    // Done on the final WAIT cycle wins over the timeout.
    job(0, 64'hC0DF, 64, 64'h5555);
    enable = 1;
    wait_drain("t4b", 300);
    enable = 0;
    chk("t4b_err", {63'h0, err_timeout}, 64'h0);
    chk("t4b_cnt", {32'h0, dec_cnt, enc_cnt}, {32'h0, 16'd3, 16'd4});

    // Key change mid-job, then reset during WAIT.
    key = 64'hAAAA_BBBB_CCCC_DDDD;
    job(1, 64'hD00D, -1, 64'h0);
    enable = 1;
    wait_for(2, "t5_ren", a);
    key = 64'h1234_5678_9ABC_DEF0;
    wait_for(0, "t5_start", s);
    chk("t5_key_start", core_key, 64'hAAAA_BBBB_CCCC_DDDD);
    tick(5);
    chk("t5_key_wait", core_key, 64'hAAAA_BBBB_CCCC_DDDD);
    chk("t5_busy_wait", {63'h0, busy}, 64'h1);
    rst = 1;
    enable = 0;
    tick(1);
    chk_reset_outputs("t5_rst");
    rst = 0;
    enc_q.push_back(64'hE9);
    dec_q.push_back(64'hD9);
    tick(10);
    chk("t5_disabled_busy", {63'h0, busy}, 64'h0);
    chk("t5_disabled_ren", 64'(din_log.size()), 64'd7);
    lat_q.push_back(1); resp_q.push_back(64'h7777_0001); exp_q.push_back('{1'b1, 64'h7777_0001, 4});
    lat_q.push_back(1); resp_q.push_back(64'h7777_0002); exp_q.push_back('{1'b0, 64'h7777_0002, 4});
    enable = 1;
    wait_drain("t5", 100);
    enable = 0;
    chk("t5_cnt", {32'h0, dec_cnt, enc_cnt}, {32'h0, 16'd1, 16'd1});

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
